// File: rtl/dataint_crc_pkg.sv
// Shared state type and byte-mask/bit-order helpers for the dataint CRC stream engine.
// Helpers take 64-bit operands; callers zero-extend narrower values.
package dataint_crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } crc_state_e;

    localparam int MAX_W = 64;

    function automatic int keep_to_count(input logic [MAX_W-1:0] keep);
        int   cnt;
        logic run;
        cnt = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            run = run & keep[i];
            if (run) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic keep_is_contig(input logic [MAX_W-1:0] keep);
        logic seen_zero;
        logic ok;
        seen_zero = 1'b0;
        ok        = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            if (!keep[i]) seen_zero = 1'b1;
            else if (seen_zero) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [MAX_W-1:0] reflect(input logic [MAX_W-1:0] value, input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) r[i] = value[6'(width - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/dataint_crc_xor_shift_cascade.sv
// One-byte CRC update stage (MSB-first shift register, optional input byte reflection).
// Latency: purely combinational.
// Backpressure: none; chained by the stream engine.
module dataint_crc_xor_shift_cascade #(
    parameter int CRC_WIDTH = 32,
    parameter int REFIN     = 1
) (
    input  logic [CRC_WIDTH-1:0] poly_i,
    input  logic [CRC_WIDTH-1:0] crc_i,
    input  logic [7:0]           data_i,
    output logic [CRC_WIDTH-1:0] crc_o
);

    logic [7:0]           byte_w;
    logic [CRC_WIDTH-1:0] c;

    always_comb begin
        byte_w = data_i;
        if (REFIN != 0) begin
            for (int i = 0; i < 8; i++) byte_w[i] = data_i[7-i];
        end
        c = crc_i;
        for (int i = 7; i >= 0; i--) begin
            if (c[CRC_WIDTH-1] ^ byte_w[i]) c = (c << 1) ^ poly_i;
            else                            c = c << 1;
        end
        crc_o = c;
    end

endmodule

// File: rtl/dataint_crc_stream.sv
// Framed valid/ready CRC engine; DATAINT_CRC_STREAM_CHECK_EN adds an expected-CRC compare.
// Latency: o_crc_valid one cycle after the accepted last beat.
// Backpressure: o_ready is low while a result waits in HOLD for i_crc_ready.
module dataint_crc_stream
    import dataint_crc_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CHUNKS     = DATA_WIDTH / 8,
    parameter int CRC_WIDTH  = 32,
    parameter int REFIN      = 1,
    parameter int REFOUT     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [CRC_WIDTH-1:0]  POLY,
    input  logic [CRC_WIDTH-1:0]  POLY_INIT,
    input  logic [CRC_WIDTH-1:0]  XOROUT,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [CHUNKS-1:0]     i_keep,
    input  logic                  i_first,
    input  logic                  i_last,
    output logic                  o_crc_valid,
    input  logic                  i_crc_ready,
    output logic [CRC_WIDTH-1:0]  o_crc,
    output logic                  o_busy,
    output logic                  o_keep_err
`ifdef DATAINT_CRC_STREAM_CHECK_EN
    ,
    input  logic [CRC_WIDTH-1:0]  i_expected_crc,
    output logic                  o_crc_match
`endif
);

    crc_state_e           state_q, state_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic [CRC_WIDTH-1:0] out_crc_q, out_crc_d;
    logic                 out_vld_q, out_vld_d;
    logic                 keep_err_q, keep_err_d;

    logic                 accept_w;
    logic [CRC_WIDTH-1:0] seed_w;
    logic [CRC_WIDTH-1:0] sel_w;
    logic [CRC_WIDTH-1:0] fin_w;
    logic [CRC_WIDTH-1:0] stage_w [CHUNKS+1];
    int                   nbytes_w;

    assign o_ready  = !out_vld_q;
    assign accept_w = i_valid && o_ready;
    assign seed_w   = (i_first || state_q == IDLE) ? POLY_INIT : crc_q;
    assign nbytes_w = keep_to_count(MAX_W'(i_keep));
    assign stage_w[0] = seed_w;

    for (genvar g = 0; g < CHUNKS; g++) begin : g_byte
        dataint_crc_xor_shift_cascade #(
            .CRC_WIDTH (CRC_WIDTH),
            .REFIN     (REFIN)
        ) u_stage (
            .poly_i (POLY),
            .crc_i  (stage_w[g]),
            .data_i (i_data[8*g +: 8]),
            .crc_o  (stage_w[g+1])
        );
    end

    // Tap n of the cascade holds the CRC after the n contiguous kept bytes.
    always_comb begin
        sel_w = seed_w;
        for (int k = 0; k <= CHUNKS; k++) begin
            if (k == nbytes_w) sel_w = stage_w[k];
        end
        if (REFOUT != 0) fin_w = CRC_WIDTH'(reflect(MAX_W'(sel_w), CRC_WIDTH)) ^ XOROUT;
        else             fin_w = sel_w ^ XOROUT;
    end

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        out_crc_d  = out_crc_q;
        out_vld_d  = out_vld_q;
        keep_err_d = accept_w && !keep_is_contig(MAX_W'(i_keep));
        case (state_q)
            IDLE, ACCUM: if (accept_w) state_d = i_last ? HOLD : ACCUM;
            HOLD:        if (i_crc_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        if (accept_w) begin
            crc_d = i_last ? POLY_INIT : sel_w;
            if (i_last) begin
                out_crc_d = fin_w;
                out_vld_d = 1'b1;
            end
        end else if (out_vld_q && i_crc_ready) begin
            out_vld_d = 1'b0;
        end
    end

    // crc_q resets to 0: in IDLE the cascade is always seeded from POLY_INIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            crc_q      <= '0;
            out_crc_q  <= '0;
            out_vld_q  <= 1'b0;
            keep_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            out_crc_q  <= out_crc_d;
            out_vld_q  <= out_vld_d;
            keep_err_q <= keep_err_d;
        end
    end

    assign o_crc       = out_crc_q;
    assign o_crc_valid = out_vld_q;
    assign o_busy      = (state_q != IDLE);
    assign o_keep_err  = keep_err_q;

`ifdef DATAINT_CRC_STREAM_CHECK_EN
    logic match_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                 match_q <= 1'b0;
        else if (accept_w && i_last)  match_q <= (fin_w == i_expected_crc);
    end

    assign o_crc_match = match_q;
`endif

endmodule

// File: tb/tb_dataint_crc_stream.sv
// Directed bench: CRC-32 and CRC-16/CCITT-FALSE instances driven with known check strings.
module tb_dataint_crc_stream;

    logic        clk;
    logic        rst_n;
    logic        v32, v16, crc_ready;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        first, last;
    logic        rdy32, cv32, busy32, kerr32;
    logic [31:0] crc32;
    logic        rdy16, cv16, busy16, kerr16;
    logic [15:0] crc16;
    int          checks;
    int          errors;
`ifdef DATAINT_CRC_STREAM_CHECK_EN
    logic [31:0] exp_crc;
    logic        match32, match16;
`endif

    dataint_crc_stream #(.DATA_WIDTH(64), .CRC_WIDTH(32), .REFIN(1), .REFOUT(1)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n),
        .POLY(32'h04C11DB7), .POLY_INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
        .i_valid(v32), .o_ready(rdy32), .i_data(data), .i_keep(keep),
        .i_first(first), .i_last(last),
        .o_crc_valid(cv32), .i_crc_ready(crc_ready), .o_crc(crc32),
        .o_busy(busy32), .o_keep_err(kerr32)
`ifdef DATAINT_CRC_STREAM_CHECK_EN
        , .i_expected_crc(exp_crc), .o_crc_match(match32)
`endif
    );

    dataint_crc_stream #(.DATA_WIDTH(64), .CRC_WIDTH(16), .REFIN(0), .REFOUT(0)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n),
        .POLY(16'h1021), .POLY_INIT(16'hFFFF), .XOROUT(16'h0000),
        .i_valid(v16), .o_ready(rdy16), .i_data(data), .i_keep(keep),
        .i_first(first), .i_last(last),
        .o_crc_valid(cv16), .i_crc_ready(crc_ready), .o_crc(crc16),
        .o_busy(busy16), .o_keep_err(kerr16)
`ifdef DATAINT_CRC_STREAM_CHECK_EN
        , .i_expected_crc(16'h0000), .o_crc_match(match16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Drives one beat and returns one cycle after it is accepted; waited = cycles stalled.
    task automatic beat(input bit sel16, input logic [63:0] d, input logic [7:0] k,
                        input bit f, input bit l, output int waited);
        data = d; keep = k; first = f; last = l;
        if (sel16) v16 = 1'b1; else v32 = 1'b1;
        waited = 0;
        while ((sel16 ? !rdy16 : !rdy32) && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (waited >= 50) begin
            errors++;
            $display("FAIL beat_ready_timeout: o_ready=0 after %0d cycles, required 1", waited);
        end
        @(posedge clk); #1;
        v16 = 1'b0; v32 = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (cv32 !== 1'b0)      begin errors++; $display("FAIL reset_crc_valid: got %b required 0", cv32); end
        checks++; if (crc32 !== 32'h0)    begin errors++; $display("FAIL reset_crc: got %h required 00000000", crc32); end
        checks++; if (kerr32 !== 1'b0)    begin errors++; $display("FAIL reset_keep_err: got %b required 0", kerr32); end
        checks++; if (busy32 !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b required 0", busy32); end
        checks++; if ({cv16, busy16, kerr16} !== 3'b000) begin errors++; $display("FAIL reset_crc16_flags: got %b required 000", {cv16, busy16, kerr16}); end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (rdy32 !== 1'b1)     begin errors++; $display("FAIL reset_ready: got %b required 1", rdy32); end
    endtask

    task automatic test_crc32();
        int w;
        beat(0, 64'h3837363534333231, 8'hFF, 1, 0, w);
        @(negedge clk);
        checks++; if (busy32 !== 1'b1)    begin errors++; $display("FAIL crc32_busy: got %b required 1", busy32); end
        checks++; if (cv32 !== 1'b0)      begin errors++; $display("FAIL crc32_early_valid: got %b required 0", cv32); end
        beat(0, 64'h39, 8'h01, 0, 1, w);
        @(negedge clk);
        checks++; if (cv32 !== 1'b1)      begin errors++; $display("FAIL crc32_valid: got %b required 1", cv32); end
        checks++; if (crc32 !== 32'hCBF43926) begin errors++; $display("FAIL crc32_value: got %h required CBF43926", crc32); end
        @(negedge clk);
        checks++; if (cv32 !== 1'b0)      begin errors++; $display("FAIL crc32_valid_drop: got %b required 0", cv32); end
        checks++; if (crc32 !== 32'hCBF43926) begin errors++; $display("FAIL crc32_value_kept: got %h required CBF43926", crc32); end
        checks++; if (busy32 !== 1'b0)    begin errors++; $display("FAIL crc32_idle: got %b required 0", busy32); end
    endtask

    task automatic test_crc16();
        int w;
        beat(1, 64'h333231, 8'h07, 1, 0, w);
        beat(1, 64'h393837363534, 8'h3F, 0, 1, w);
        @(negedge clk);
        checks++; if (cv16 !== 1'b1)      begin errors++; $display("FAIL crc16_valid: got %b required 1", cv16); end
        checks++; if (crc16 !== 16'h29B1) begin errors++; $display("FAIL crc16_value: got %h required 29B1", crc16); end
    endtask

    task automatic test_short_frames();
        int w;
        beat(0, 64'h61, 8'h01, 1, 1, w);
        @(negedge clk);
        checks++; if (crc32 !== 32'hE8B7BE43) begin errors++; $display("FAIL single_byte_a: got %h required E8B7BE43", crc32); end
        beat(0, 64'h0, 8'h00, 1, 1, w);
        @(negedge clk);
        checks++; if (crc32 !== 32'h00000000) begin errors++; $display("FAIL empty_frame: got %h required 00000000", crc32); end
        beat(0, 64'h3837363534333231, 8'hFF, 1, 0, w);
        beat(0, 64'h39, 8'h01, 0, 0, w);
        beat(0, 64'hDEADBEEF, 8'h00, 0, 1, w);
        @(negedge clk);
        checks++; if (crc32 !== 32'hCBF43926) begin errors++; $display("FAIL empty_last_beat: got %h required CBF43926", crc32); end
    endtask

    task automatic test_restart();
        int w;
        beat(0, 64'h4241, 8'h03, 1, 0, w);
        beat(0, 64'h3837363534333231, 8'hFF, 1, 0, w);
        beat(0, 64'h39, 8'h01, 0, 1, w);
        @(negedge clk);
        checks++; if (crc32 !== 32'hCBF43926) begin errors++; $display("FAIL first_restart: got %h required CBF43926", crc32); end
    endtask

    task automatic test_bad_keep();
        int w;
        beat(0, 64'h3837363534333231, 8'hFF, 1, 0, w);
        @(negedge clk);
        checks++; if (kerr32 !== 1'b0)    begin errors++; $display("FAIL keep_err_clean: got %b required 0", kerr32); end
        beat(0, 64'h0000000000AA0039, 8'h05, 0, 1, w);
        @(negedge clk);
        checks++; if (kerr32 !== 1'b1)    begin errors++; $display("FAIL keep_err_pulse: got %b required 1", kerr32); end
        checks++; if (crc32 !== 32'hCBF43926) begin errors++; $display("FAIL keep_err_value: got %h required CBF43926", crc32); end
        @(negedge clk);
        checks++; if (kerr32 !== 1'b0)    begin errors++; $display("FAIL keep_err_once: got %b required 0", kerr32); end
    endtask

    task automatic test_backpressure();
        int w;
        crc_ready = 1'b0;
        beat(0, 64'h3837363534333231, 8'hFF, 1, 0, w);
        beat(0, 64'h39, 8'h01, 0, 1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b required 0", i, rdy32); end
            checks++; if (cv32 !== 1'b1)  begin errors++; $display("FAIL bp_valid[%0d]: got %b required 1", i, cv32); end
            checks++; if (crc32 !== 32'hCBF43926) begin errors++; $display("FAIL bp_value[%0d]: got %h required CBF43926", i, crc32); end
        end
        crc_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (cv32 !== 1'b0)      begin errors++; $display("FAIL bp_valid_drop: got %b required 0", cv32); end
        checks++; if (rdy32 !== 1'b1)     begin errors++; $display("FAIL bp_ready_back: got %b required 1", rdy32); end
        checks++; if (crc32 !== 32'hCBF43926) begin errors++; $display("FAIL bp_value_kept: got %h required CBF43926", crc32); end
        beat(0, 64'h61, 8'h01, 1, 1, w);
        checks++; if (w !== 0)            begin errors++; $display("FAIL bp_next_frame_stall: got %0d cycles required 0", w); end
        @(negedge clk);
        checks++; if (crc32 !== 32'hE8B7BE43) begin errors++; $display("FAIL bp_next_frame: got %h required E8B7BE43", crc32); end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        beat(0, 64'h3837363534333231, 8'hFF, 1, 0, w);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy32 !== 1'b0)    begin errors++; $display("FAIL rst_mid_busy: got %b required 0", busy32); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (cv32 !== 1'b0)  begin errors++; $display("FAIL rst_mid_stale_valid[%0d]: got %b required 0", i, cv32); end
        end
        beat(0, 64'h3837363534333231, 8'hFF, 0, 0, w);
        beat(0, 64'h39, 8'h01, 0, 1, w);
        @(negedge clk);
        checks++; if (cv32 !== 1'b1)      begin errors++; $display("FAIL rst_mid_valid: got %b required 1", cv32); end
        checks++; if (crc32 !== 32'hCBF43926) begin errors++; $display("FAIL rst_mid_value: got %h required CBF43926", crc32); end
    endtask

`ifdef DATAINT_CRC_STREAM_CHECK_EN
    task automatic test_check();
        int w;
        exp_crc = 32'hCBF43926;
        beat(0, 64'h3837363534333231, 8'hFF, 1, 0, w);
        beat(0, 64'h39, 8'h01, 0, 1, w);
        @(negedge clk);
        checks++; if (match32 !== 1'b1)   begin errors++; $display("FAIL check_match: got %b required 1", match32); end
        exp_crc = 32'hCBF43927;
        beat(0, 64'h3837363534333231, 8'hFF, 1, 0, w);
        beat(0, 64'h39, 8'h01, 0, 1, w);
        @(negedge clk);
        checks++; if (match32 !== 1'b0)   begin errors++; $display("FAIL check_mismatch: got %b required 0", match32); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; v32 = 1'b0; v16 = 1'b0; crc_ready = 1'b1;
        data = '0; keep = '0; first = 1'b0; last = 1'b0;
`ifdef DATAINT_CRC_STREAM_CHECK_EN
        exp_crc = '0;
`endif
        test_reset();
        test_crc32();
        test_crc16();
        test_short_frames();
        test_restart();
        test_bad_keep();
        test_backpressure();
        test_reset_mid_frame();
`ifdef DATAINT_CRC_STREAM_CHECK_EN
        test_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
